udp_vec_sequencer: RTL and testbench

UDP_VEC_SEQUENCER -- requirements
Module: udp_vec_sequencer

---
 rtl/udp_vec_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_udp_vec_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_vec_sequencer.sv
// Purpose : on-chip vector sequencer that drives a small table of {b,c} stimuli into a primitive and checks its output a.
// Latency : start cycle to done pulse is N*(SETTLE+2)+1 cycles, or 2 cycles for an empty run (N=0).
// Backprs : no handshake; start and table writes are dropped while busy, and results hold until the next accepted start.
//
// Ports:
//   clk, rst                    clock (rising edge) and synchronous active-high reset
//   wr_en, wr_addr, wr_data     vector table write port, wr_data = {care, exp_a, b, c}; ignored while busy
//   vec_count, start            run request; vec_count (clamped to NUM_VEC) is latched on an accepted start
//   drv_b, drv_c, smp_a         stimulus to and response from the primitive under test
//   busy, done                  run in progress; one-cycle completion pulse
//   pass, err_cnt, err_idx      run result, mismatch count (saturating), first failing vector index
//
// Optional build macro: UDP_SEQ_STOP_ON_ERR_EN -- finish the run on the first counted mismatch.
module udp_vec_sequencer #(
  parameter  int NUM_VEC = 8,
  parameter  int SETTLE  = 1,
  localparam int AW      = $clog2(NUM_VEC),
  localparam int CW      = AW + 1,
  localparam int EW      = $clog2(NUM_VEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [CW-1:0] vec_count,
  input  logic          start,
  output logic          drv_b,
  output logic          drv_c,
  input  logic          smp_a,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_cnt,
  output logic [AW-1:0] err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    settle_q, settle_d;
  logic          drv_b_q, drv_b_d;
  logic          drv_c_q, drv_c_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic          pass_q, pass_d;
  logic          zero_q, zero_d;

  // Table contents survive reset so a run can be repeated after an abort.
  logic [3:0]    table_q [NUM_VEC];

  logic [3:0]    entry;
  logic [CW-1:0] count_clamped;
  logic          mismatch;
  logic          last;
  logic          stop;

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE) && (32'(wr_addr) < NUM_VEC)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    settle_d      = settle_q;
    drv_b_d       = drv_b_q;
    drv_c_d       = drv_c_q;
    err_cnt_d     = err_cnt_q;
    err_idx_d     = err_idx_q;
    pass_d        = pass_q;
    zero_d        = zero_q;
    entry         = table_q[idx_q];
    count_clamped = (vec_count > CW'(NUM_VEC)) ? CW'(NUM_VEC) : vec_count;
    mismatch      = entry[3] && (smp_a != entry[2]);
    last          = ({1'b0, idx_q} == (count_q - CW'(1)));
`ifdef UDP_SEQ_STOP_ON_ERR_EN
    stop          = last || mismatch;
`else
    stop          = last;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d   = count_clamped;
          idx_d     = '0;
          err_cnt_d = '0;
          err_idx_d = '0;
          pass_d    = 1'b0;
          if (count_clamped == '0) begin
            state_d = S_DONE;
            zero_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        drv_b_d  = entry[1];
        drv_c_d  = entry[0];
        settle_d = 4'(SETTLE - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != {EW{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (err_cnt_q == '0) begin
            err_idx_d = idx_q;
          end
        end
        if (stop) begin
          state_d = S_DONE;
        end else begin
          state_d = S_APPLY;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        // An empty run idles one extra cycle here so its report lands two cycles after start.
        if (zero_q) begin
          zero_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Resolve pass on entry to DONE so it is already valid alongside the done pulse.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      settle_q  <= '0;
      drv_b_q   <= 1'b0;
      drv_c_q   <= 1'b0;
      err_cnt_q <= '0;
      err_idx_q <= '0;
      pass_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      settle_q  <= settle_d;
      drv_b_q   <= drv_b_d;
      drv_c_q   <= drv_c_d;
      err_cnt_q <= err_cnt_d;
      err_idx_q <= err_idx_d;
      pass_q    <= pass_d;
      zero_q    <= zero_d;
    end
  end

  assign drv_b   = drv_b_q;
  assign drv_c   = drv_c_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) && !zero_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_udp_vec_sequencer.sv
module tb_udp_vec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] vec_count;
  logic       start;
  logic       drv_b, drv_c;
  logic       smp_a;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] err_idx;

  int mode;   // 0: correct OR, 1: output stuck at 0, 2: wrong only for {c,b}=10
  int nchk = 0;
  int nerr = 0;

`ifdef UDP_SEQ_STOP_ON_ERR_EN
  localparam int STK_LAT = 7;
  localparam int STK_CNT = 1;
`else
  localparam int STK_LAT = 13;
  localparam int STK_CNT = 3;
`endif

  udp_vec_sequencer #(.NUM_VEC(8), .SETTLE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .vec_count(vec_count),
    .start    (start),
    .drv_b    (drv_b),
    .drv_c    (drv_c),
    .smp_a    (smp_a),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .err_idx  (err_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       smp_a = drv_b | drv_c;
      1:       smp_a = 1'b0;
      default: smp_a = (drv_b | drv_c) ^ (drv_c & ~drv_b);
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Runs one sequence; inj>0 pulses start and a table write during that busy cycle.
  task automatic run(input int cnt, input int inj, input logic dowr, input logic [2:0] wa,
                     input logic [3:0] wd, output int lat, output int p, output int ec, output int ei);
    int cyc;
    lat = -1; p = -1; ec = -1; ei = -1;
    @(posedge clk); #1;
    start = 1'b1; vec_count = cnt[3:0];
    if (dowr) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
    end
    cyc = 0;
    while (lat < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (cyc == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b1100; vec_count = 4'd1;
      end
      if (done === 1'b1) begin
        lat = cyc; p = int'(pass); ec = int'(err_cnt); ei = int'(err_idx);
      end
    end
    start = 1'b0; wr_en = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle_then_idle", {30'd0, done, busy}, 0);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    cnt;
    int    exp_lat;
    int    exp_pass;
    int    exp_ec;
    int    exp_ei;
  } row_t;

  row_t rows[5];

  initial begin
    int lat, p, ec, ei;
    int ndone;
    logic [1:0] drv_before;

    rows[0] = '{"or_ok",        0, 4,  13,      1, 0,       0};
    rows[1] = '{"or_stuck0",    1, 4,  STK_LAT, 0, STK_CNT, 1};
    rows[2] = '{"count_zero",   0, 0,  2,       1, 0,       0};
    rows[3] = '{"count_clamp",  0, 15, 25,      1, 0,       0};
    rows[4] = '{"stuck_2vec",   1, 2,  7,       0, 1,       1};

    mode = 0; rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; vec_count = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {20'd0, busy, done, pass, err_cnt, err_idx, drv_b, drv_c}, 0);
    rst = 1'b0;

    // OR truth table in entries 0..3, don't-care filler in 4..7
    wr(3'd0, 4'b1000);
    wr(3'd1, 4'b1110);
    wr(3'd2, 4'b1101);
    wr(3'd3, 4'b1111);
    for (int i = 4; i < 8; i++) wr(3'(i), 4'b0000);

    for (int i = 0; i < 5; i++) begin
      mode = rows[i].mode;
      drv_before = {drv_b, drv_c};
      run(rows[i].cnt, -1, 1'b0, 3'd0, 4'd0, lat, p, ec, ei);
      chk({rows[i].name, "_latency"}, lat, rows[i].exp_lat);
      chk({rows[i].name, "_pass"},    p,   rows[i].exp_pass);
      chk({rows[i].name, "_err_cnt"}, ec,  rows[i].exp_ec);
      chk({rows[i].name, "_err_idx"}, ei,  rows[i].exp_ei);
      chk({rows[i].name, "_pass_held"}, 32'(pass), rows[i].exp_pass);
      if (rows[i].cnt == 0) chk("count_zero_drv_unchanged", {30'd0, drv_b, drv_c}, {30'd0, drv_before});
    end

    // Reset asserted during cycle 5 of a 4-vector run
    mode = 1;
    @(posedge clk); #1;
    start = 1'b1; vec_count = 4'd4;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_regs", {28'd0, busy, done, drv_b, drv_c}, 0);
    chk("abort_results_clear", {25'd0, pass, err_cnt, err_idx}, 0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run(4, -1, 1'b0, 3'd0, 4'd0, lat, p, ec, ei);
    chk("rerun_latency", lat, STK_LAT);
    chk("rerun_err_cnt", ec, STK_CNT);
    chk("rerun_err_idx", ei, 1);
    chk("rerun_pass", p, 0);

    // Write and start in the same idle cycle: entry 3 now expects 0, OR model gives 1
    mode = 0;
    run(4, -1, 1'b1, 3'd3, 4'b1011, lat, p, ec, ei);
    chk("wr_start_latency", lat, 13);
    chk("wr_start_pass", p, 0);
    chk("wr_start_err_cnt", ec, 1);
    chk("wr_start_err_idx", ei, 3);
    wr(3'd3, 4'b1111);

    // Entry 2 don't-care against a model wrong only there; start/write while busy dropped
    wr(3'd2, 4'b0101);
    mode = 2;
    run(4, 4, 1'b0, 3'd0, 4'd0, lat, p, ec, ei);
    chk("dontcare_latency", lat, 13);
    chk("dontcare_pass", p, 1);
    chk("dontcare_err_cnt", ec, 0);
    run(4, -1, 1'b0, 3'd0, 4'd0, lat, p, ec, ei);
    chk("busy_write_ignored_pass", p, 1);
    chk("busy_write_ignored_err_cnt", ec, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
